// File: rtl/demux_dispatch.sv
// Routes one data word to one of KEY_NUM registered lanes on a rising edge of wr, with
// round-robin auto pointer. Define DEMUX_DISPATCH_WRITE_ONCE_EN to reject rewrites of valid lanes.
module demux_dispatch #(
  parameter int unsigned KEY_NUM  = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KEY_LEN-1:0]           key,
  input  logic [DATA_LEN-1:0]          data,
  input  logic                         wr,
  input  logic                         clr,
  input  logic                         auto_mode,
  output logic [KEY_NUM*DATA_LEN-1:0]  lanes,
  output logic [KEY_NUM-1:0]           lane_valid,
  output logic [KEY_LEN-1:0]           ptr,
  output logic                         err,
  output logic [CNT_W-1:0]             wr_cnt
);

`ifdef DEMUX_DISPATCH_WRITE_ONCE_EN
  localparam bit WriteOnce = 1'b1;
`else
  localparam bit WriteOnce = 1'b0;
`endif

  logic                        wr_q, clr_q;
  logic                        wr_rise, clr_rise;
  logic [KEY_NUM*DATA_LEN-1:0] lanes_q, lanes_d;
  logic [KEY_NUM-1:0]          valid_q, valid_d;
  logic [KEY_LEN-1:0]          ptr_q, ptr_d;
  logic                        err_q, err_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [KEY_LEN-1:0]          tgt;
  logic [KEY_NUM-1:0]          hit;
  logic                        in_range;
  logic                        occupied;

  assign wr_rise  = wr & ~wr_q;
  assign clr_rise = clr & ~clr_q;
  assign tgt      = auto_mode ? ptr_q : key;
  assign in_range = 32'(tgt) < KEY_NUM;

  // One-hot lane decode avoids indexing past KEY_NUM when the key space is larger.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      hit[i] = (tgt == KEY_LEN'(i));
    end
  end

  assign occupied = |(hit & valid_q);

  always_comb begin
    lanes_d = lanes_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (clr_rise) begin
      lanes_d = '0;
      valid_d = '0;
      ptr_d   = '0;
      err_d   = 1'b0;
    end else if (wr_rise) begin
      if (!in_range || (WriteOnce && occupied)) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < KEY_NUM; i++) begin
          if (hit[i]) lanes_d[i*DATA_LEN +: DATA_LEN] = data;
        end
        valid_d = valid_q | hit;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (auto_mode) begin
          ptr_d = (ptr_q == KEY_LEN'(KEY_NUM - 1)) ? '0 : ptr_q + KEY_LEN'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      clr_q   <= 1'b0;
      lanes_q <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_q    <= wr;
      clr_q   <= clr;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lanes      = lanes_q;
  assign lane_valid = valid_q;
  assign ptr        = ptr_q;
  assign err        = err_q;
  assign wr_cnt     = cnt_q;

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch: a reference model pushes expected outputs per cycle
// into a scoreboard queue, popped and compared after the DUT's clock edge.
module tb_demux_dispatch;

  typedef struct packed {
    logic [7:0] lanes;
    logic [3:0] valid;
    logic [1:0] ptr;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] data;
  logic       wr, clr, auto_mode;
  logic [7:0] lanes;
  logic [3:0] lane_valid;
  logic [1:0] ptr;
  logic       err;
  logic [3:0] wr_cnt;
  logic [5:0] lanes3;
  logic [2:0] valid3;
  logic [1:0] ptr3;
  logic       err3;
  logic [3:0] cnt3;

  int   checks = 0;
  int   errors = 0;
  exp_t model;
  exp_t sb[$];
  logic prev_wr, prev_clr;

  always #5 clk = ~clk;

  demux_dispatch #(.KEY_NUM(4), .KEY_LEN(2), .DATA_LEN(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .key(key), .data(data), .wr(wr), .clr(clr),
    .auto_mode(auto_mode), .lanes(lanes), .lane_valid(lane_valid), .ptr(ptr),
    .err(err), .wr_cnt(wr_cnt)
  );

  demux_dispatch #(.KEY_NUM(3), .KEY_LEN(2), .DATA_LEN(2), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .key(key), .data(data), .wr(wr), .clr(clr),
    .auto_mode(auto_mode), .lanes(lanes3), .lane_valid(valid3), .ptr(ptr3),
    .err(err3), .wr_cnt(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed none expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".lanes"}, 32'(lanes), 32'(e.lanes));
    chk({tag, ".valid"}, 32'(lane_valid), 32'(e.valid));
    chk({tag, ".ptr"}, 32'(ptr), 32'(e.ptr));
    chk({tag, ".err"}, 32'(err), 32'(e.err));
    chk({tag, ".cnt"}, 32'(wr_cnt), 32'(e.cnt));
  endtask

  task automatic model_reset();
    model    = '0;
    prev_wr  = 1'b0;
    prev_clr = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic c);
    logic rise_w, rise_c;
    int   t;
    rise_w   = w & ~prev_wr;
    rise_c   = c & ~prev_clr;
    prev_wr  = w;
    prev_clr = c;
    t = auto_mode ? int'(model.ptr) : int'(key);
    if (rise_c) begin
      model.lanes = '0;
      model.valid = '0;
      model.ptr   = '0;
      model.err   = 1'b0;
    end else if (rise_w) begin
`ifdef DEMUX_DISPATCH_WRITE_ONCE_EN
      if (model.valid[t]) begin
        model.err = 1'b1;
        return;
      end
`endif
      model.lanes[t*2 +: 2] = data;
      model.valid[t] = 1'b1;
      if (model.cnt != 4'hF) model.cnt = model.cnt + 4'd1;
      if (auto_mode) model.ptr = (model.ptr == 2'd3) ? 2'd0 : model.ptr + 2'd1;
    end
  endtask

  // Called at a falling edge: drive levels, predict, let one rising edge pass, compare.
  task automatic cycle(input string tag, input logic w, input logic c);
    wr  = w;
    clr = c;
    model_step(w, c);
    sb.push_back(model);
    @(posedge clk);
    @(negedge clk);
    compare_front(tag);
  endtask

  task automatic pulse(input string tag, input logic [1:0] k, input logic [1:0] d);
    key  = k;
    data = d;
    cycle(tag, 1'b1, 1'b0);
    cycle(tag, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs checked before any clock edge.
  task automatic async_reset(input string tag, input logic hold_wr);
    #2 rst = 1'b1;
    #1;
    model_reset();
    sb.push_back(model);
    compare_front(tag);
    wr = hold_wr;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key = '0; data = '0; wr = 1'b0; clr = 1'b0; auto_mode = 1'b0;
    model_reset();
    @(negedge clk);
    sb.push_back(model);
    compare_front("reset");
    rst = 1'b0;

    // Out-of-range key on the 3-lane instance.
    key = 2'd3; data = 2'd2;
    cycle("oor", 1'b1, 1'b0);
    chk("oor3.err", 32'(err3), 32'd1);
    chk("oor3.lanes", 32'(lanes3), 32'd0);
    chk("oor3.valid", 32'(valid3), 32'd0);
    chk("oor3.cnt", 32'(cnt3), 32'd0);
    cycle("oor", 1'b0, 1'b0);
    chk("oor3.sticky", 32'(err3), 32'd1);
    async_reset("rst1", 1'b0);

    // Manual routing.
    key = 2'd2; data = 2'b11;
    cycle("manual", 1'b1, 1'b0);
    chk("manual.lanes", 32'(lanes), 32'h30);
    chk("manual.valid", 32'(lane_valid), 32'h4);
    cycle("manual", 1'b0, 1'b0);
    async_reset("rst2", 1'b0);

    // Held level gives exactly one write.
    key = 2'd1; data = 2'b01;
    for (int i = 0; i < 10; i++) cycle("held", 1'b1, 1'b0);
    cycle("held", 1'b0, 1'b0);
    chk("held.cnt", 32'(wr_cnt), 32'd1);
    chk("held.valid", 32'(lane_valid), 32'h2);
    async_reset("rst3", 1'b0);

    // Auto fill with wrap; last write overwrites lane 0.
    auto_mode = 1'b1;
    pulse("auto", 2'd0, 2'd0);
    pulse("auto", 2'd0, 2'd1);
    pulse("auto", 2'd0, 2'd2);
    pulse("auto", 2'd0, 2'd3);
    pulse("auto", 2'd0, 2'd1);
    chk("auto.lanes", 32'(lanes), 32'b11_10_01_01);
    chk("auto.valid", 32'(lane_valid), 32'hF);
    chk("auto.ptr", 32'(ptr), 32'd1);
    chk("auto.cnt", 32'(wr_cnt), 32'd5);

    // Pointer survives a mode toggle and a manual write.
    auto_mode = 1'b0;
    pulse("toggle", 2'd2, 2'd0);
    auto_mode = 1'b1;
    pulse("toggle", 2'd0, 2'd3);
    auto_mode = 1'b0;

    // Clear wins over a simultaneous write.
    key = 2'd0; data = 2'd3;
    cycle("clrprio", 1'b1, 1'b1);
    chk("clrprio.lanes", 32'(lanes), 32'd0);
    chk("clrprio.cnt", 32'(wr_cnt), 32'd7);
    cycle("clrprio", 1'b0, 1'b0);

    // Saturation.
    for (int i = 0; i < 20; i++) pulse("sat", 2'(i), 2'(i + 1));
    chk("sat.cnt", 32'(wr_cnt), 32'hF);
    for (int i = 0; i < 3; i++) cycle("sathold", 1'b0, 1'b0);

    // Async reset with lanes populated, then wr held high through deassertion.
    async_reset("arst", 1'b1);
    key = 2'd1; data = 2'd2;
    cycle("wrthru", 1'b1, 1'b0);
    chk("wrthru.lanes", 32'(lanes), 32'h08);
    cycle("wrthru", 1'b0, 1'b0);

    // Rewrite of a valid lane.
    pulse("rewr", 2'd3, 2'd1);
    pulse("rewr", 2'd3, 2'd2);
`ifdef DEMUX_DISPATCH_WRITE_ONCE_EN
    chk("wonce.lane3", 32'(lanes[7:6]), 32'd1);
    chk("wonce.err", 32'(err), 32'd1);
`else
    chk("overwr.lane3", 32'(lanes[7:6]), 32'd2);
    chk("overwr.err", 32'(err), 32'd0);
`endif
    cycle("endclr", 1'b0, 1'b1);
    cycle("endclr", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
